// File: rtl/cpu_pkg.sv
// Shared types for the CPU control unit: opcodes, FSM states, jump
// conditions, the decoded instruction class and the stack-pointer reset value.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ALU_RR   = 4'h0,
        OP_ALU_IMM4 = 4'h1,
        OP_IMM8     = 4'h2,
        OP_LOAD     = 4'h3,
        OP_STORE    = 4'h4,
        OP_JMP      = 4'h5,
        OP_CALL     = 4'h6,
        OP_HALT     = 4'h7,
        OP_PUSH     = 4'h8
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM_WAIT  = 3'd3,
        S_WRITEBACK = 3'd4,
        S_JUMP      = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_N      = 4'd3,
        COND_NN     = 4'd4
    } cond_e;

    // One-hot instruction class; illegal opcodes fold into nop.
    typedef struct packed {
        logic alu_rr;
        logic alu_imm4;
        logic imm8;
        logic load;
        logic store;
        logic jmp;
        logic call;
        logic halt;
        logic push;
        logic nop;
    } instr_class_t;

    localparam logic [15:0] SP_RESET_VALUE = 16'h8000;

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath bundle: instruction and flags in, control strobes
// and debug/status out. master = controller, slave = datapath.
interface cpu_controller_if;
    logic [15:0] current_instruction;
    logic        Z_out;
    logic        N_out;

    logic        reg_write;
    logic        mem_to_reg;
    logic        fetch_instruction;
    logic        alu_override_imm8;
    logic        alu_override_imm4;
    logic        alu_set_flags;
    logic        set_pc;
    logic        pc_from_register;
    logic        mem_write;
    logic        mem_write_is_stack;
    logic        mem_write_next_pc;
    logic        set_sp;
    logic        increase_sp;

    logic        halted;
    logic [15:0] retired;
    logic [2:0]  state_poke;

    modport master (
        input  current_instruction, Z_out, N_out,
        output reg_write, mem_to_reg, fetch_instruction, alu_override_imm8,
               alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
               mem_write, mem_write_is_stack, mem_write_next_pc, set_sp,
               increase_sp, halted, retired, state_poke
    );

    modport slave (
        output current_instruction, Z_out, N_out,
        input  reg_write, mem_to_reg, fetch_instruction, alu_override_imm8,
               alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
               mem_write, mem_write_is_stack, mem_write_next_pc, set_sp,
               increase_sp, halted, retired, state_poke
    );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: opcode -> one-hot class, and
// jump condition evaluated against the Z/N status flags.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0]   opcode,
    input  logic [3:0]   cond,
    input  logic         z_flag,
    input  logic         n_flag,
    output instr_class_t instr_class,
    output logic         jump_taken
);

    // Opcode to class; anything unmapped executes as a NOP.
    always_comb begin
        instr_class = '0;
        case (opcode)
            OP_ALU_RR:   instr_class.alu_rr   = 1'b1;
            OP_ALU_IMM4: instr_class.alu_imm4 = 1'b1;
            OP_IMM8:     instr_class.imm8     = 1'b1;
            OP_LOAD:     instr_class.load     = 1'b1;
            OP_STORE:    instr_class.store    = 1'b1;
            OP_JMP:      instr_class.jmp      = 1'b1;
            OP_CALL:     instr_class.call     = 1'b1;
            OP_HALT:     instr_class.halt     = 1'b1;
            OP_PUSH:     instr_class.push     = 1'b1;
            default:     instr_class.nop      = 1'b1;
        endcase
    end

    // Jump condition; undefined codes are never taken.
    always_comb begin
        jump_taken = 1'b0;
        case (cond)
            COND_ALWAYS: jump_taken = 1'b1;
            COND_Z:      jump_taken = z_flag;
            COND_NZ:     jump_taken = ~z_flag;
            COND_N:      jump_taken = n_flag;
            COND_NN:     jump_taken = ~n_flag;
            default:     jump_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXECUTE [-> MEM_WAIT ->
// WRITEBACK | -> JUMP] with a retired-instruction counter.
// Optional feature macro: CPU_SINGLE_STEP_EN adds step_mode/step inputs that
// gate FETCH so one instruction runs per rising edge of step.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 1
)
(
    input  logic clock,
    input  logic reset,
`ifdef CPU_SINGLE_STEP_EN
    input  logic step_mode,
    input  logic step,
`endif
    cpu_controller_if.master bus
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT_CYCLES - 1);

    state_e       state_reg, state_next;
    logic [3:0]   wait_cnt_reg, wait_cnt_next;
    logic [15:0]  retired_reg;
    logic         retire_now;
    logic         fetch_go;
    instr_class_t cls;
    logic         jump_taken;

    logic c_reg_write, c_mem_to_reg, c_fetch, c_imm8, c_imm4, c_set_flags;
    logic c_set_pc, c_pc_from_reg, c_mem_write, c_is_stack, c_next_pc, c_set_sp;

    // Operand fields are consumed by the datapath, not here.
    logic unused_operands;
    assign unused_operands = ^bus.current_instruction[11:4];

    cpu_decoder u_decoder (
        .opcode      (bus.current_instruction[15:12]),
        .cond        (bus.current_instruction[3:0]),
        .z_flag      (bus.Z_out),
        .n_flag      (bus.N_out),
        .instr_class (cls),
        .jump_taken  (jump_taken)
    );

`ifdef CPU_SINGLE_STEP_EN
    logic step_d_reg, step_pending_reg, step_pending_next, step_rise;
    assign step_rise = step & ~step_d_reg;
    assign fetch_go  = ~step_mode | step_pending_reg | step_rise;

    // Remember a step edge that arrives mid-instruction; consume it on fetch.
    always_comb begin
        step_pending_next = step_pending_reg;
        if (state_reg == S_FETCH && fetch_go)
            step_pending_next = 1'b0;
        else if (step_rise)
            step_pending_next = 1'b1;
    end

    // Step edge detector and pending flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_d_reg       <= 1'b0;
            step_pending_reg <= 1'b0;
        end else begin
            step_d_reg       <= step;
            step_pending_reg <= step_pending_next;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    // State, wait counter and retired counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 4'd0;
            retired_reg  <= 16'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire_now)
                retired_reg <= retired_reg + 16'd1;
        end
    end

    // Next state and per-state control decode.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        retire_now    = 1'b0;
        c_reg_write   = 1'b0;
        c_mem_to_reg  = 1'b0;
        c_fetch       = 1'b0;
        c_imm8        = 1'b0;
        c_imm4        = 1'b0;
        c_set_flags   = 1'b0;
        c_set_pc      = 1'b0;
        c_pc_from_reg = 1'b0;
        c_mem_write   = 1'b0;
        c_is_stack    = 1'b0;
        c_next_pc     = 1'b0;
        c_set_sp      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (fetch_go) begin
                    c_fetch    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = cls.halt ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                state_next = S_FETCH;
                retire_now = 1'b1;
                if (cls.alu_rr || cls.alu_imm4) begin
                    c_reg_write = 1'b1;
                    c_set_flags = 1'b1;
                    c_set_pc    = 1'b1;
                    c_imm4      = cls.alu_imm4;
                end
                if (cls.imm8) begin
                    c_reg_write = 1'b1;
                    c_imm8      = 1'b1;
                    c_set_pc    = 1'b1;
                end
                if (cls.load) begin
                    state_next    = S_MEM_WAIT;
                    retire_now    = 1'b0;
                    wait_cnt_next = WAIT_INIT;
                end
                if (cls.store) begin
                    c_mem_write = 1'b1;
                    c_set_pc    = 1'b1;
                end
                if (cls.push) begin
                    c_mem_write = 1'b1;
                    c_is_stack  = 1'b1;
                    c_set_pc    = 1'b1;
                    c_set_sp    = 1'b1;
                end
                if (cls.jmp) begin
                    c_set_pc      = 1'b1;
                    c_pc_from_reg = jump_taken;
                end
                if (cls.call) begin
                    c_mem_write = 1'b1;
                    c_is_stack  = 1'b1;
                    c_next_pc   = 1'b1;
                    c_set_sp    = 1'b1;
                    state_next  = S_JUMP;
                    retire_now  = 1'b0;
                end
            end
            S_MEM_WAIT: begin
                if (wait_cnt_reg == 4'd0)
                    state_next = S_WRITEBACK;
                else
                    wait_cnt_next = wait_cnt_reg - 4'd1;
            end
            S_WRITEBACK: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
                c_set_pc     = 1'b1;
                retire_now   = 1'b1;
                state_next   = S_FETCH;
            end
            S_JUMP: begin
                c_set_pc      = 1'b1;
                c_pc_from_reg = 1'b1;
                retire_now    = 1'b1;
                state_next    = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Outputs; controls are forced low for as long as reset is held.
    always_comb begin
        bus.reg_write          = reset & c_reg_write;
        bus.mem_to_reg         = reset & c_mem_to_reg;
        bus.fetch_instruction  = reset & c_fetch;
        bus.alu_override_imm8  = reset & c_imm8;
        bus.alu_override_imm4  = reset & c_imm4;
        bus.alu_set_flags      = reset & c_set_flags;
        bus.set_pc             = reset & c_set_pc;
        bus.pc_from_register   = reset & c_pc_from_reg;
        bus.mem_write          = reset & c_mem_write;
        bus.mem_write_is_stack = reset & c_is_stack;
        bus.mem_write_next_pc  = reset & c_next_pc;
        bus.set_sp             = reset & c_set_sp;
        bus.increase_sp        = 1'b0;
        bus.halted             = (state_reg == S_HALT);
        bus.retired            = retired_reg;
        bus.state_poke         = state_reg;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter MEM_WAIT_CYCLES, default 1: cycles spent in MEM_WAIT for LOAD; legal range 1..15.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 current_instruction  in  16  latched instruction from the datapath: [15:12] opcode, [11:8] r1, [7:4] r2/imm4, [3:0] alu_op/cond.
REQ-005 Z_out, N_out  in  1 each  status flags from the datapath SR.
REQ-006 reg_write, mem_to_reg, fetch_instruction, alu_override_imm8, alu_override_imm4, alu_set_flags  out  1 each  datapath controls.
REQ-007 set_pc, pc_from_register, mem_write, mem_write_is_stack, mem_write_next_pc, set_sp, increase_sp  out  1 each  datapath controls.
REQ-008 halted  out  1  high while in HALT.
REQ-009 retired  out  16  count of completed instructions.
REQ-010 state_poke  out  3  current state encoding, for debug.

Function
REQ-011 States: FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, JUMP, HALT.
REQ-012 FETCH asserts fetch_instruction for exactly one cycle, then goes to DECODE.
REQ-013 DECODE asserts no controls and goes to EXECUTE, or to HALT when opcode=0x7.
REQ-014 Opcode map:
- 0x0 ALU reg-reg
- 0x1 ALU imm4
- 0x2 IMM8
- 0x3 LOAD
- 0x4 STORE
- 0x5 JMP
- 0x6 CALL
- 0x7 HALT
- 0x8 PUSH
- 0x9..0xF illegal, executed as NOP
REQ-015 ALU reg-reg: EXECUTE asserts reg_write, alu_set_flags and set_pc, then goes to FETCH.
REQ-016 ALU imm4: same as REQ-015, plus alu_override_imm4.
REQ-017 IMM8: EXECUTE asserts reg_write, alu_override_imm8 and set_pc; it does not assert alu_set_flags.
REQ-018 LOAD: EXECUTE asserts no controls; MEM_WAIT holds for MEM_WAIT_CYCLES using an internal down-counter; WRITEBACK asserts reg_write, mem_to_reg and set_pc.
REQ-019 STORE: EXECUTE asserts mem_write and set_pc.
REQ-020 PUSH: EXECUTE asserts mem_write, mem_write_is_stack and set_pc, plus set_sp with increase_sp=0.
REQ-021 JMP cond=[3:0]: 0 always, 1 Z, 2 !Z, 3 N, 4 !N; values 5..15 are never taken.
REQ-022 JMP taken: EXECUTE asserts set_pc and pc_from_register. JMP not taken: EXECUTE asserts set_pc only.
REQ-023 CALL: EXECUTE asserts mem_write, mem_write_is_stack and mem_write_next_pc with pc_from_register=0, plus set_sp with increase_sp=0.
REQ-024 CALL: JUMP, the following cycle, asserts set_pc and pc_from_register, then goes to FETCH.
REQ-025 Every control output not listed for a state is 0; all outputs are decoded combinationally from the registered state and the instruction.
REQ-026 mem_write, reg_write, set_pc and set_sp are each high for at most one cycle per instruction.
REQ-027 retired increments by 1 on the last cycle of each instruction (EXECUTE, WRITEBACK or JUMP) and wraps from 0xFFFF to 0x0000.
REQ-028 HALT is terminal: all controls are 0, halted=1 and retired is frozen; only reset exits.
REQ-029 Instruction latency in cycles:
- 3 for ALU, IMM8, STORE, PUSH, JMP and NOP
- 4 for CALL
- 4+MEM_WAIT_CYCLES for LOAD

Reset
REQ-030 Asserting reset forces state=FETCH, retired=0, wait counter=0 and halted=0, and drives every control output to 0 immediately, including mid-instruction.
REQ-031 The first fetch occurs on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro CPU_SINGLE_STEP_EN adds two inputs: step_mode (1 bit) and step (1 bit, rising-edge detected internally).
REQ-033 With CPU_SINGLE_STEP_EN defined and step_mode=1, the controller holds in FETCH with all controls 0 until a step rising edge; it then executes exactly one instruction.
REQ-034 With CPU_SINGLE_STEP_EN defined and step_mode=0, behaviour is identical to the macro being undefined.
REQ-035 Without CPU_SINGLE_STEP_EN, the step ports do not exist and FETCH never stalls.

Structure
REQ-036 Package cpu_pkg holds:
- the opcode enum (4 bits)
- the state enum (3 bits)
- the jump-condition enum
- the localparam reset SP value 16'h8000
REQ-037 Sub-module cpu_decoder (combinational) maps opcode and cond plus Z/N to a class one-hot and a jump_taken bit; the FSM and counters stay in cpu_controller.

Verification
REQ-038 Reset, then instruction 0x0120 (ALU r1,r2,op0) -> fetch_instruction high on cycle 1; reg_write, alu_set_flags and set_pc high on cycle 3; retired=1.
REQ-039 LOAD 0x3340 with MEM_WAIT_CYCLES=2 -> reg_write and mem_to_reg asserted only on cycle 6; no other write in cycles 2-5.
REQ-040 JMP cond=1 (0x5201): with Z_out=1, pc_from_register=1 in EXECUTE; with Z_out=0, set_pc=1 and pc_from_register=0.
REQ-041 CALL 0x6500 -> EXECUTE: mem_write, mem_write_is_stack, mem_write_next_pc and set_sp high, increase_sp=0; JUMP: set_pc and pc_from_register high; total 4 cycles.
REQ-042 HALT 0x7000, then 20 cycles -> halted=1, all controls 0, retired unchanged; reset pulse mid-HALT -> state FETCH and retired=0.
REQ-043 retired preloaded to 0xFFFF by running 65535 NOPs, then one more NOP -> retired=0x0000.
